// File: rtl/cnt_pkg.sv
// cnt_pkg: shared timer state encoding and mode constants for the counter family
package cnt_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} tmr_state_t;
  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;
endpackage

// File: rtl/tick_gen.sv
// tick_gen: one-cycle tick every PRE enabled cycles, cleared synchronously by clr
module tick_gen #(
  parameter int PRE = 4
) (
  input  logic Clk,
  input  logic resetn,
  input  logic clr,
  input  logic en,
  output logic tick
);
  localparam int W = PRE > 2 ? $clog2(PRE) : 1;
  localparam logic [W-1:0] LAST = W'(PRE - 1);
  logic [W-1:0] cnt;
  assign tick = en && !clr && cnt == LAST;
  always_ff @(posedge Clk or negedge resetn)
    if (!resetn) cnt <= '0;
    else cnt <= clr ? '0 : !en ? cnt : cnt == LAST ? '0 : cnt + W'(1);
endmodule

// File: rtl/cnt_dn_ld_tmr.sv
// cnt_dn_ld_tmr: loadable one-shot/periodic down-counter timer; prescaler enabled by CNT_DN_LD_TMR_PRESCALE_EN
module cnt_dn_ld_tmr
  import cnt_pkg::*;
#(
  parameter int n = 4,
  parameter int PRE = 4
) (
  input  logic         Clk,
  input  logic         resetn,
  input  logic         en,
  input  logic         ld,
  input  logic         mode,
  input  logic [n-1:0] D,
  output logic [n-1:0] q,
  output logic         tc,
  output logic         busy,
  output logic         done
);
  localparam logic [n-1:0] ONE = n'(1);
  tmr_state_t state;
  logic [n-1:0] reload_r;
  logic mode_r, adv, term;
`ifdef CNT_DN_LD_TMR_PRESCALE_EN
  tick_gen #(.PRE(PRE)) u_tick (
    .Clk(Clk),
    .resetn(resetn),
    .clr(ld || state != RUN),
    .en(en),
    .tick(adv)
  );
`else
  assign adv = en;
`endif
  assign term = state == RUN && adv && q == ONE;
  assign busy = state == RUN;
  always_ff @(posedge Clk or negedge resetn)
    if (!resetn) begin
      q <= '0;
      reload_r <= '0;
      mode_r <= MODE_ONESHOT;
      state <= IDLE;
      tc <= 1'b0;
      done <= 1'b0;
    end else if (ld) begin
      q <= D;
      reload_r <= D;
      mode_r <= mode;
      done <= 1'b0;
      tc <= 1'b0;
      state <= D != '0 ? RUN : IDLE;
    end else begin
      tc <= term;
      if (state == RUN && adv)
        q <= q != ONE ? q - ONE : mode_r == MODE_PERIODIC ? reload_r : '0;
      if (term && mode_r == MODE_ONESHOT) begin
        done <= 1'b1;
        state <= DONE;
      end
    end
endmodule

// File: tb/tb_cnt_dn_ld_tmr.sv
// tb_cnt_dn_ld_tmr: directed and random stimulus against a behavioural timer model
module tb_cnt_dn_ld_tmr;
  localparam int N = 4;
  logic Clk = 1'b0, resetn = 1'b0, en = 1'b0, ld = 1'b0, mode = 1'b0;
  logic [N-1:0] D = '0, q;
  logic tc, busy, done;
  int errors = 0, checks = 0;
  int m_q, m_rel;
  bit m_periodic, m_running, m_done, m_tc;
  cnt_dn_ld_tmr #(.n(N), .PRE(4)) dut (
    .Clk(Clk), .resetn(resetn), .en(en), .ld(ld), .mode(mode),
    .D(D), .q(q), .tc(tc), .busy(busy), .done(done)
  );
  always #5 Clk = ~Clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic check_all(input string tag);
    check({tag, ".q"}, 32'(q), m_q);
    check({tag, ".tc"}, 32'(tc), 32'(m_tc));
    check({tag, ".busy"}, 32'(busy), 32'(m_running));
    check({tag, ".done"}, 32'(done), 32'(m_done));
  endtask
  task automatic model_reset();
    m_q = 0; m_rel = 0; m_periodic = 0; m_running = 0; m_done = 0; m_tc = 0;
  endtask
  task automatic step(input string tag, input bit l, input bit e, input bit m, input int d);
    ld = l; en = e; mode = m; D = d[N-1:0];
    @(posedge Clk);
    m_tc = 0;
    if (l) begin
      m_q = d % (1 << N); m_rel = m_q; m_periodic = m; m_done = 0; m_running = m_q != 0;
    end else if (m_running && e) begin
      if (m_q > 1) m_q--;
      else begin
        m_tc = 1;
        if (m_periodic) m_q = m_rel;
        else begin m_q = 0; m_running = 0; m_done = 1; end
      end
    end
    @(negedge Clk);
    check_all(tag);
  endtask
  initial begin
    bit pat [8] = '{1, 0, 0, 1, 1, 0, 1, 1};
    model_reset();
    #12 check_all("rst_held");
    @(negedge Clk) resetn = 1'b1;
    repeat (5) step("idle_en", 0, 1, 0, 0);
    step("ld3_os", 1, 0, 0, 3);
    repeat (8) step("run_os", 0, 1, 0, 0);
    step("ld2_per", 1, 0, 1, 2);
    repeat (8) step("run_per", 0, 1, 0, 0);
    step("ld5_os", 1, 0, 0, 5);
    foreach (pat[i]) step("en_pat", 0, pat[i], 0, 0);
    step("ld2_again", 1, 0, 0, 2);
    step("to_one", 0, 1, 0, 0);
    step("ld_at_term", 1, 1, 0, 9);
    step("ld_zero", 1, 1, 1, 0);
    step("idle_after0", 0, 1, 0, 0);
    step("ld6", 1, 0, 0, 6);
    #2 resetn = 1'b0;
    #1 model_reset();
    check_all("async_rst");
    @(negedge Clk) resetn = 1'b1;
    step("post_rst", 0, 1, 0, 0);
    step("per1_ld", 1, 0, 1, 1);
    repeat (4) step("per1_run", 0, 1, 0, 0);
    repeat (400)
      step("rand", $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0,
           1'($urandom_range(0, 1)), int'($urandom_range(0, 15)));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
